// File: rtl/cadc_pkg.sv
// Shared widths and serializer state type for the CADC microprogram serial path.
package cadc_pkg;
    localparam int CADC_WORD_W = 20;
    localparam int CADC_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } ser_state_t;
endpackage

// File: rtl/rom_word_serializer_addr_gen.sv
// ROM address sequencer: registered address, wrap-around increment, one pending jump
// slot that redirects the next prefetch, and a pulse on the natural 127 -> 0 wrap.
module rom_addr_gen
    import cadc_pkg::*;
#(
    parameter int ADDR_W = CADC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              latch,
    input  logic              advance,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;

    // A jump arriving on the same edge as an advance wins over any older pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                addr       <= jump_addr;
                pend_valid <= 1'b0;
            end else if (advance) begin
                pend_valid <= 1'b0;
                if (latch) begin
                    addr <= jump_addr;
                end else if (pend_valid) begin
                    addr <= pend_addr;
                end else begin
                    addr <= addr + ADDR_W'(1);
                    wrap <= (addr == '1);
                end
            end else if (latch) begin
                pend_valid <= 1'b1;
                pend_addr  <= jump_addr;
            end
        end
    end
endmodule

// File: rtl/rom_word_serializer.sv
// Serializes CADC microprogram ROM words LSB-first on bit_en strobes, prefetching the
// next word into a hold register while the current one shifts so words abut.
module rom_word_serializer
    import cadc_pkg::*;
#(
    parameter int WORD_W  = CADC_WORD_W,
    parameter int ADDR_W  = CADC_ADDR_W,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              run,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              ser_out,
    output logic              word_sync,
    output logic              word_mark,
    output logic              busy,
    output logic              addr_wrap,
    output logic              underrun
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int LAT_W = $clog2(ROM_LAT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT);

    ser_state_t        state;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] hold;
    logic              hold_valid;
    logic              pf_busy;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              is_idle;
    logic              advance;

    assign is_idle = (state == IDLE);
    assign advance = (state == SHIFT) && bit_en && (bit_cnt == '0);

    rom_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (is_idle && jump_valid),
        .latch    (!is_idle && jump_valid),
        .advance  (advance),
        .jump_addr(jump_addr),
        .addr     (rom_addr),
        .wrap     (addr_wrap)
    );

    // Data is sampled ROM_LAT+1 edges after the address edge: ROM_LAT for the ROM
    // itself plus the capture edge. FETCH and prefetch never overlap, so they share
    // lat_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            pf_busy    <= 1'b0;
            bit_cnt    <= '0;
            lat_cnt    <= '0;
            ser_out    <= 1'b0;
            word_sync  <= 1'b0;
            word_mark  <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        lat_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        sreg    <= rom_data;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                SHIFT: begin
                    if (pf_busy) begin
                        if (lat_cnt == LAT_LAST) begin
                            hold       <= rom_data;
                            hold_valid <= 1'b1;
                            pf_busy    <= 1'b0;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                    if (bit_en) begin
                        ser_out   <= sreg[0];
                        word_sync <= (bit_cnt == '0);
                        word_mark <= (bit_cnt == BIT_LAST);
                        if (bit_cnt == '0) begin
                            pf_busy <= 1'b1;
                            lat_cnt <= '0;
                        end
                        // The last bit decides whether the stream continues, stops, or starves.
                        if (bit_cnt != BIT_LAST) begin
                            sreg    <= sreg >> 1;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (!run) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            hold_valid <= 1'b0;
                            pf_busy    <= 1'b0;
                        end else if (hold_valid) begin
                            sreg       <= hold;
                            hold_valid <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            underrun <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            pf_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_word_serializer.sv
// Self-checking bench: random ROM image and bit_en patterns, serial words reassembled
// by a monitor and compared with the word sequence expected from the addressing rules.
module tb_rom_word_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_en = 1'b0;
    logic        run = 1'b0;
    logic        jump_valid = 1'b0;
    logic [6:0]  jump_addr = '0;
    logic [6:0]  rom_addr;
    logic [19:0] rom_data = '0;
    logic        ser_out, word_sync, word_mark, busy, addr_wrap, underrun;

    int checks = 0;
    int errors = 0;
    int en_mode = 0;
    int tb_cyc = 0;

    logic [19:0] rom [128];

    typedef struct {
        logic [19:0] data;
        bit          frame_ok;
        int          gap;
    } word_rec_t;
    word_rec_t rx_q[$];

    bit          in_word = 0;
    int          bit_idx = 0;
    int          strobes = 0;
    int          cur_gap = 0;
    logic [19:0] acc = '0;
    bit          frame_ok = 1;
    int          wrap_cnt = 0;
    logic [6:0]  wrap_addr = '0;
    logic        mon_en, mon_rst;

    rom_word_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .run       (run),
        .jump_valid(jump_valid),
        .jump_addr (jump_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ser_out   (ser_out),
        .word_sync (word_sync),
        .word_mark (word_mark),
        .busy      (busy),
        .addr_wrap (addr_wrap),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one clock of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Monitor: rebuilds words from the strobe-by-strobe serial output.
    always @(posedge clk) begin
        mon_en  = bit_en;
        mon_rst = rst;
        #1;
        if (addr_wrap === 1'b1) begin
            wrap_cnt++;
            wrap_addr = rom_addr;
        end
        if (mon_rst) begin
            in_word = 0;
            bit_idx = 0;
            strobes = 0;
        end else if (mon_en) begin
            strobes++;
            if (word_sync === 1'b1) begin
                cur_gap  = strobes;
                strobes  = 0;
                in_word  = 1;
                bit_idx  = 0;
                acc      = '0;
                frame_ok = 1;
            end
            if (in_word) begin
                acc[bit_idx] = ser_out;
                if (word_sync !== (bit_idx == 0) || word_mark !== (bit_idx == 19)) frame_ok = 0;
                bit_idx++;
                if (bit_idx == 20) begin
                    rx_q.push_back('{acc, frame_ok, cur_gap});
                    in_word = 0;
                    bit_idx = 0;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        tb_cyc++;
        jump_valid = 1'b0;
        case (en_mode)
            0:       bit_en = 1'b1;
            1:       bit_en = (tb_cyc % 4 == 0);
            default: bit_en = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        rx_q.delete();
        wrap_cnt = 0;
    endtask

    task automatic wait_words(input int want, input int budget);
        for (int n = 0; n < budget && rx_q.size() < want; n++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b1;
        en_mode = 0;
        repeat (3) step();
        checks++;
        if ({rom_addr, ser_out, word_sync, word_mark, busy, addr_wrap, underrun} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got addr=%0h ser=%b sync=%b mark=%b busy=%b wrap=%b und=%b expected all 0",
                     rom_addr, ser_out, word_sync, word_mark, busy, addr_wrap, underrun);
        end
        rx_q.delete();
        rst = 1'b0;
        wait_words(2, 200);
        checks++;
        if (rx_q.size() < 2) begin
            errors++;
            $display("[TB] FAIL first_words_count: got %0d expected 2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rx_q[i].data !== rom[i]) begin
                    errors++;
                    $display("[TB] FAIL first_word_data[%0d]: got %05h expected %05h", i, rx_q[i].data, rom[i]);
                end
                checks++;
                if (rx_q[i].frame_ok !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL first_word_framing[%0d]: got %0d expected 1", i, rx_q[i].frame_ok);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en_mode = 1;
        run = 1'b1;
        wait_words(4, 1500);
        checks++;
        if (rx_q.size() < 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[i].data !== rom[i] || rx_q[i].frame_ok !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_word[%0d]: got %05h framing %0d expected %05h framing 1",
                             i, rx_q[i].data, rx_q[i].frame_ok, rom[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (rx_q[i].gap != 20) begin
                        errors++;
                        $display("[TB] FAIL b2b_gap[%0d]: got %0d strobes expected 20", i, rx_q[i].gap);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        en_mode = 2;
        step();
        jump_valid = 1'b1;
        jump_addr  = 7'd124;
        step();
        step();
        checks++;
        if (rom_addr !== 7'd124) begin
            errors++;
            $display("[TB] FAIL idle_jump_addr: got %0d expected 124", rom_addr);
        end
        run = 1'b1;
        wait_words(6, 1500);
        checks++;
        if (rx_q.size() < 6) begin
            errors++;
            $display("[TB] FAIL wrap_count: got %0d expected 6", rx_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                logic [6:0] a;
                a = 7'd124 + 7'(i);
                checks++;
                if (rx_q[i].data !== rom[a]) begin
                    errors++;
                    $display("[TB] FAIL wrap_word[%0d]: got %05h expected %05h (addr %0d)", i, rx_q[i].data, rom[a], a);
                end
            end
        end
        checks++;
        if (wrap_cnt != 1 || wrap_addr !== 7'd0) begin
            errors++;
            $display("[TB] FAIL wrap_pulse: got %0d cycles at addr %0d expected 1 cycle at addr 0", wrap_cnt, wrap_addr);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_underrun: got %b expected 0", underrun);
        end
    endtask

    task automatic test_jump();
        logic [6:0] tgt;
        logic [6:0] exp_a[$];
        do_reset();
        en_mode = 2;
        run = 1'b1;
        tgt = 7'($urandom_range(60, 120));
        for (int n = 0; n < 500 && !(rx_q.size() == 1 && in_word && bit_idx == 5); n++) step();
        jump_valid = 1'b1;
        jump_addr  = 7'd40;
        step();
        en_mode = 0;
        for (int n = 0; n < 800 && !(rx_q.size() == 5 && in_word && bit_idx == 19); n++) step();
        step();
        jump_valid = 1'b1;
        jump_addr  = tgt;
        wait_words(9, 800);
        // Word 1's prefetch (addr 2) is already done when the first jump arrives, so it
        // steers the following prefetch; the second jump lands on a prefetch edge itself.
        exp_a = '{7'd0, 7'd1, 7'd2, 7'd40, 7'd41, 7'd42, 7'd43, tgt, tgt + 7'd1};
        checks++;
        if (rx_q.size() < 9) begin
            errors++;
            $display("[TB] FAIL jump_count: got %0d expected 9", rx_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (rx_q[i].data !== rom[exp_a[i]] || rx_q[i].frame_ok !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL jump_word[%0d]: got %05h framing %0d expected %05h (addr %0d)",
                             i, rx_q[i].data, rx_q[i].frame_ok, rom[exp_a[i]], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_run_stop();
        int n;
        do_reset();
        en_mode = 2;
        run = 1'b1;
        for (n = 0; n < 500 && !(rx_q.size() == 1 && in_word && bit_idx == 10); n++) step();
        run = 1'b0;
        for (n = 0; n < 300 && busy !== 1'b0; n++) step();
        checks++;
        if (busy !== 1'b0 || rx_q.size() != 2 || in_word) begin
            errors++;
            $display("[TB] FAIL stop_complete: got busy=%b words=%0d partial=%0d expected busy=0 words=2 partial=0",
                     busy, rx_q.size(), in_word);
        end
        checks++;
        if (rx_q.size() >= 2 && (rx_q[1].data !== rom[1] || rx_q[1].frame_ok !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL stop_last_word: got %05h framing %0d expected %05h framing 1",
                     rx_q[1].data, rx_q[1].frame_ok, rom[1]);
        end
        checks++;
        if (rom_addr !== 7'd2 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_addr: got addr=%0d und=%b expected addr=2 und=0", rom_addr, underrun);
        end
        repeat (5) step();
        run = 1'b1;
        wait_words(4, 500);
        checks++;
        if (rx_q.size() < 4 || rx_q[2].data !== rom[2] || rx_q[3].data !== rom[3]) begin
            errors++;
            $display("[TB] FAIL resume_words: got %0d words expected %05h %05h next", rx_q.size(), rom[2], rom[3]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        en_mode = 0;
        run = 1'b1;
        for (int n = 0; n < 200 && !(rx_q.size() == 0 && in_word && bit_idx == 12); n++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({rom_addr, ser_out, word_sync, word_mark, busy, addr_wrap, underrun} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got addr=%0h ser=%b sync=%b mark=%b busy=%b wrap=%b und=%b expected all 0",
                     rom_addr, ser_out, word_sync, word_mark, busy, addr_wrap, underrun);
        end
        rst = 1'b0;
        rx_q.delete();
        wait_words(1, 200);
        checks++;
        if (rx_q.size() < 1 || rx_q[0].data !== rom[0] || rx_q[0].frame_ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_word: got %0d words expected first %05h intact", rx_q.size(), rom[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 20'($urandom);
        rom[0] = 20'h00001;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_jump();
        test_run_stop();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
